ifetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 72 +++++++
 rtl/ifetch_unit.sv | 97 +++++++++
 tb/tb_ifetch_unit.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// ============================================================================
// fetch_pkg : shared types and constants for the instruction-fetch slice
// Rev 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

  localparam logic [31:0] c_reset_pc = 32'h0000_0000;
  localparam logic [31:0] c_nop      = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// fetch_fifo : synchronous FIFO of fetch entries with flush
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  fetch_entry_t             i_data,
  output fetch_entry_t             o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty,
  output logic                     o_full
);

  localparam int                c_aw      = $clog2(DEPTH);
  localparam logic [c_aw:0]     c_depth   = DEPTH[c_aw:0];
  localparam logic [c_aw:0]     c_cnt_one = 1;
  localparam logic [c_aw-1:0]   c_ptr_one = 1;

  fetch_entry_t        r_mem [DEPTH];
  logic [c_aw-1:0]     r_wptr;
  logic [c_aw-1:0]     r_rptr;
  logic [c_aw:0]       r_count;
  logic                w_do_push;
  logic                w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == c_depth);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // Storage carries no reset; validity is tracked by r_count alone.
  always_ff @(posedge clk_i) begin
    if (w_do_push && !i_flush) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + c_ptr_one;
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + c_ptr_one;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/ifetch_unit.sv
// ============================================================================
// ifetch_unit : PC sequencer driving a synchronous-read imem, buffering words
//               for decode over valid/ready, with flush-and-restart redirect
// Rev 1.0
// ============================================================================
`default_nettype none

module ifetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = c_reset_pc,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o
);

  localparam int               c_aw    = $clog2(FIFO_DEPTH);
  localparam logic [c_aw+1:0]  c_limit = FIFO_DEPTH[c_aw+1:0];
  localparam logic [31:0]      c_step  = 32'd4;

  logic [31:0]   r_pc;
  logic [31:0]   r_resp_pc;
  logic          r_inflight;

  logic          w_pop;
  logic          w_push;
  logic          w_issue;
  logic [c_aw:0] w_count;
  logic [c_aw+1:0] w_occ;
  logic          w_empty;
  logic          w_full;
  logic          w_unused_bits;
  fetch_entry_t  w_head;
  fetch_entry_t  w_resp;

  assign imem_addr_o   = r_pc;
  assign instr_valid_o = ~w_empty;
  assign w_pop         = instr_valid_o & instr_ready_i;

  // Buffered plus in-flight words, minus the one leaving, must leave a free slot.
  assign w_occ   = {1'b0, w_count} + {{(c_aw+1){1'b0}}, r_inflight}
                 - {{(c_aw+1){1'b0}}, w_pop};
  assign w_issue = ~redirect_i & (w_occ < c_limit);

  assign w_push       = r_inflight & ~redirect_i;
  assign w_resp.instr = imem_data_i;
  assign w_resp.pc    = r_resp_pc;

  assign instr_o    = w_empty ? '0 : w_head.instr;
  assign instr_pc_o = w_empty ? '0 : w_head.pc;

  assign w_unused_bits = ^{redirect_pc_i[1:0], w_full};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pc       <= RESET_PC;
      r_resp_pc  <= '0;
      r_inflight <= 1'b0;
    end else if (redirect_i) begin
      r_pc       <= {redirect_pc_i[31:2], 2'b00};
      r_inflight <= 1'b0;
    end else if (w_issue) begin
      r_pc       <= r_pc + c_step;
      r_resp_pc  <= r_pc;
      r_inflight <= 1'b1;
    end else begin
      r_inflight <= 1'b0;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_i),
    .i_data  (w_resp),
    .o_data  (w_head),
    .o_count (w_count),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

endmodule

`default_nettype wire

// File: tb/tb_ifetch_unit.sv
// ============================================================================
// tb_ifetch_unit : scoreboard bench for ifetch_unit with a sync-read imem model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ifetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  int vectors     = 0;
  int miscompares = 0;

  fetch_entry_t sb_q[$];
  fetch_entry_t mon_e;

  ifetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem_addr_o   (imem_addr),
    .imem_data_i   (imem_data),
    .instr_valid_o (instr_valid),
    .instr_ready_i (instr_ready),
    .instr_o       (instr),
    .instr_pc_o    (instr_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0: mem_word = 32'h0050_0093;
      32'h4: mem_word = 32'h00A0_0113;
      32'h8: mem_word = 32'h0020_81B3;
      default: mem_word = a ^ 32'hA5A5_5A5A;
    endcase
  endfunction

  // Synchronous-read instruction memory: data follows the sampled address by one cycle.
  always @(posedge clk) imem_data <= mem_word(imem_addr);

  // Scoreboard: every accepted instruction must match the next expected entry.
  always @(negedge clk) begin
    if (!rst && instr_valid && instr_ready) begin
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL sb_unexpected: got pc=%h instr=%h, required no delivery", instr_pc, instr);
      end else begin
        mon_e = sb_q.pop_front();
        if ({instr, instr_pc} !== {mon_e.instr, mon_e.pc}) begin
          miscompares++;
          $display("FAIL sb_stream: got pc=%h instr=%h, required pc=%h instr=%h",
                   instr_pc, instr, mon_e.pc, mon_e.instr);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pc(input logic [31:0] pc);
    fetch_entry_t e;
    e.pc    = pc;
    e.instr = mem_word(pc);
    sb_q.push_back(e);
  endtask

  task automatic wait_drain(output bit ok);
    int n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (sb_q.size() != 0 && n < 64);
    ok = (sb_q.size() == 0);
    #1;
    instr_ready = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!instr_valid && n < 12);
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b1;
    sb_q.delete();
    step(); step();
    @(negedge clk);
    vectors++;
    if ({instr_valid, instr, instr_pc, imem_addr} !== {1'b0, 32'h0, 32'h0, 32'h0}) begin
      miscompares++;
      $display("FAIL reset_state: got v=%b i=%h pc=%h a=%h, required v=0 i=0 pc=0 a=0",
               instr_valid, instr, instr_pc, imem_addr);
    end
  endtask

  task automatic test_startup();
    bit ok;
    expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8);
    step(); rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (instr_valid !== 1'b0) begin
      miscompares++; $display("FAIL startup_v0: got valid=%b, required 0", instr_valid);
    end
    step(); @(negedge clk);
    vectors++;
    if (instr_valid !== 1'b0) begin
      miscompares++; $display("FAIL startup_v1: got valid=%b, required 0", instr_valid);
    end
    step(); @(negedge clk);
    vectors++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
      miscompares++; $display("FAIL startup_v2: got valid=%b pc=%h, required 1 / 0", instr_valid, instr_pc);
    end
    for (int k = 0; k < 2; k++) begin
      step(); @(negedge clk);
      vectors++;
      if (instr_valid !== 1'b1) begin
        miscompares++; $display("FAIL startup_gapless: got valid=%b at beat %0d, required 1", instr_valid, k + 1);
      end
    end
    wait_drain(ok);
    vectors++;
    if (!ok) begin
      miscompares++; $display("FAIL startup_drain: got %0d undelivered, required 0", sb_q.size()); sb_q.delete();
    end
  endtask

  task automatic test_stall();
    bit ok;
    rst = 1'b1; instr_ready = 1'b0; sb_q.delete();
    step(); step(); rst = 1'b0;
    for (int k = 0; k < 5; k++) expect_pc(32'(k * 4));
    step(); step(); @(negedge clk);
    vectors++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
      miscompares++; $display("FAIL stall_first: got valid=%b pc=%h, required 1 / 0", instr_valid, instr_pc);
    end
    for (int k = 0; k < 6; k++) begin
      step(); @(negedge clk);
      vectors++;
      if ({instr_valid, instr_pc, imem_addr} !== {1'b1, 32'h0, 32'h8}) begin
        miscompares++;
        $display("FAIL stall_hold: got valid=%b pc=%h addr=%h, required 1 / 0 / 8", instr_valid, instr_pc, imem_addr);
      end
    end
    step(); instr_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      vectors++;
      if (instr_valid !== 1'b1) begin
        miscompares++; $display("FAIL stall_gapless: got valid=%b at beat %0d, required 1", instr_valid, k);
      end
      if (k < 4) step();
    end
    wait_drain(ok);
    vectors++;
    if (!ok) begin
      miscompares++; $display("FAIL stall_drain: got %0d undelivered, required 0", sb_q.size()); sb_q.delete();
    end
  endtask

  task automatic test_redirect();
    bit ok;
    rst = 1'b1; instr_ready = 1'b1; sb_q.delete();
    step(); step(); rst = 1'b0;
    expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8);
    step(); step(); step(); step();
    redirect = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    vectors++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h8) begin
      miscompares++; $display("FAIL redir_pre: got valid=%b pc=%h, required 1 / 8", instr_valid, instr_pc);
    end
    step(); redirect = 1'b0;
    expect_pc(32'h100); expect_pc(32'h104); expect_pc(32'h108);
    @(negedge clk);
    vectors++;
    if (instr_valid !== 1'b0 || imem_addr !== 32'h100) begin
      miscompares++; $display("FAIL redir_next: got valid=%b addr=%h, required 0 / 100", instr_valid, imem_addr);
    end
    step(); @(negedge clk);
    vectors++;
    if (instr_valid !== 1'b0) begin
      miscompares++; $display("FAIL redir_lat: got valid=%b, required 0", instr_valid);
    end
    step(); @(negedge clk);
    vectors++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h100) begin
      miscompares++; $display("FAIL redir_first: got valid=%b pc=%h, required 1 / 100", instr_valid, instr_pc);
    end
    wait_drain(ok);
    vectors++;
    if (!ok) begin
      miscompares++; $display("FAIL redir_drain: got %0d undelivered, required 0", sb_q.size()); sb_q.delete();
    end
  endtask

  task automatic test_redirect_unaligned();
    bit ok;
    step(); redirect = 1'b1; redirect_pc = 32'h0000_0106;
    step(); redirect = 1'b0;
    expect_pc(32'h104); expect_pc(32'h108);
    @(negedge clk);
    vectors++;
    if (instr_valid !== 1'b0 || imem_addr !== 32'h104) begin
      miscompares++; $display("FAIL unalign_addr: got valid=%b addr=%h, required 0 / 104", instr_valid, imem_addr);
    end
    step(); instr_ready = 1'b1;
    wait_valid();
    vectors++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h104) begin
      miscompares++; $display("FAIL unalign_first: got valid=%b pc=%h, required 1 / 104", instr_valid, instr_pc);
    end
    wait_drain(ok);
    vectors++;
    if (!ok) begin
      miscompares++; $display("FAIL unalign_drain: got %0d undelivered, required 0", sb_q.size()); sb_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    step(); redirect = 1'b1; redirect_pc = 32'h200;
    step(); redirect_pc = 32'h300;
    step(); redirect = 1'b0;
    expect_pc(32'h300); expect_pc(32'h304);
    @(negedge clk);
    vectors++;
    if (instr_valid !== 1'b0 || imem_addr !== 32'h300) begin
      miscompares++; $display("FAIL b2b_addr: got valid=%b addr=%h, required 0 / 300", instr_valid, imem_addr);
    end
    step(); instr_ready = 1'b1;
    wait_valid();
    vectors++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h300) begin
      miscompares++; $display("FAIL b2b_first: got valid=%b pc=%h, required 1 / 300", instr_valid, instr_pc);
    end
    wait_drain(ok);
    vectors++;
    if (!ok) begin
      miscompares++; $display("FAIL b2b_drain: got %0d undelivered, required 0", sb_q.size()); sb_q.delete();
    end
  endtask

  task automatic test_reset_midstream();
    bit ok;
    step(); step(); step();
    @(negedge clk);
    vectors++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h308) begin
      miscompares++; $display("FAIL midrst_pre: got valid=%b pc=%h, required 1 / 308", instr_valid, instr_pc);
    end
    step(); rst = 1'b1; sb_q.delete();
    step(); rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({instr_valid, instr, instr_pc, imem_addr} !== {1'b0, 32'h0, 32'h0, 32'h0}) begin
      miscompares++;
      $display("FAIL midrst_state: got v=%b i=%h pc=%h a=%h, required v=0 i=0 pc=0 a=0",
               instr_valid, instr, instr_pc, imem_addr);
    end
    expect_pc(32'h0); expect_pc(32'h4);
    step(); instr_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (instr_valid !== 1'b0) begin
      miscompares++; $display("FAIL midrst_lat: got valid=%b, required 0", instr_valid);
    end
    step(); @(negedge clk);
    vectors++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
      miscompares++; $display("FAIL midrst_first: got valid=%b pc=%h, required 1 / 0", instr_valid, instr_pc);
    end
    wait_drain(ok);
    vectors++;
    if (!ok) begin
      miscompares++; $display("FAIL midrst_drain: got %0d undelivered, required 0", sb_q.size()); sb_q.delete();
    end
  endtask

  task automatic test_wrap();
    bit ok;
    step(); redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step(); redirect = 1'b0; instr_ready = 1'b1;
    expect_pc(32'hFFFF_FFFC); expect_pc(32'h0); expect_pc(32'h4);
    @(negedge clk);
    vectors++;
    if (imem_addr !== 32'hFFFF_FFFC) begin
      miscompares++; $display("FAIL wrap_addr: got addr=%h, required fffffffc", imem_addr);
    end
    wait_valid();
    vectors++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFC) begin
      miscompares++; $display("FAIL wrap_first: got valid=%b pc=%h, required 1 / fffffffc", instr_valid, instr_pc);
    end
    wait_drain(ok);
    vectors++;
    if (!ok) begin
      miscompares++; $display("FAIL wrap_drain: got %0d undelivered, required 0", sb_q.size()); sb_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_stall();
    test_redirect();
    test_redirect_unaligned();
    test_back_to_back();
    test_reset_midstream();
    test_wrap();
    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000, required completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
